// File: rtl/framebuffer_scanout.sv
// Raster-order read engine for the palette-index framebuffer. It hides the read port's 1-cycle latency behind a 2-entry FIFO.
// Define FRAMEBUFFER_SCANOUT_SCALE2X_EN for 2x pixel doubling; the default build scans the frame 1:1.
module framebuffer_scanout #(
    parameter int SCREEN_WIDTH  = 160,
    parameter int SCREEN_HEIGHT = 120,
    parameter int INDEX_WIDTH   = 4,
    localparam int ADDR_WIDTH   = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    output logic [ADDR_WIDTH-1:0]  fb_addr,
    input  logic [INDEX_WIDTH-1:0] fb_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [INDEX_WIDTH-1:0] m_data,
    output logic                   m_sof,
    output logic                   m_eol,
    output logic                   frame_done,
    output logic [1:0]             state_dbg
);
`ifdef FRAMEBUFFER_SCANOUT_SCALE2X_EN
    localparam int SCALE = 2;
`else
    localparam int SCALE = 1;
`endif
    localparam int OUT_W = SCREEN_WIDTH * SCALE;
    localparam int OUT_H = SCREEN_HEIGHT * SCALE;
    localparam int XW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int YW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int EW    = INDEX_WIDTH + 2;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    // Stream handshake: a pixel moves when m_valid && m_ready. While m_valid is high
    // and m_ready is low, m_data/m_sof/m_eol stay unchanged.
    state_t            state_q, state_d;
    logic [XW-1:0]     x_q, x_d, x_src;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_WIDTH-1:0] row_q, row_d;
    logic              rd_q, rd_sof_q, rd_eol_q;
    logic [1:0]        occ_q, occ_d;
    logic [EW-1:0]     e0_q, e0_d, e1_q, e1_d, push_ent;
    logic [2:0]        demand;
    logic              issue, x_last, y_last, push, pop, frame_done_q;

    assign x_last   = (x_q == XW'(OUT_W - 1));
    assign y_last   = (y_q == YW'(OUT_H - 1));
    assign push     = rd_q;
    assign pop      = (occ_q != 2'd0) && m_ready;
    assign push_ent = {rd_sof_q, rd_eol_q, fb_data};
    // Reserve a slot for every read still on its way, assuming no pop next cycle.
    assign demand   = {1'b0, occ_q} + {2'b00, rd_q} - {2'b00, pop};

`ifdef FRAMEBUFFER_SCANOUT_SCALE2X_EN
    assign x_src = x_q >> 1;
`else
    assign x_src = x_q;
`endif
    assign fb_addr = row_q + ADDR_WIDTH'(x_src);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (issue && x_last && y_last) state_d = DRAIN;
            DRAIN:   if (occ_d == 2'd0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q != IDLE);
        issue = (state_q == RUN) && (demand < 3'd2);
    end

    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        row_d = row_q;
        if (state_q == IDLE && start) begin
            x_d   = '0;
            y_d   = '0;
            row_d = '0;
        end else if (issue && !(x_last && y_last)) begin
            if (x_last) begin
                x_d = '0;
                y_d = y_q + YW'(1);
                // In 2x mode each source line is scanned twice before moving on.
                if (SCALE == 1 || y_q[0]) row_d = row_q + ADDR_WIDTH'(SCREEN_WIDTH);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        occ_d = occ_q + {1'b0, push} - {1'b0, pop};
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) e0_d = push_ent;
                else               e1_d = push_ent;
            end
            2'b01: e0_d = e1_q;
            2'b11: begin
                if (occ_q == 2'd1) begin
                    e0_d = push_ent;
                end else begin
                    e0_d = e1_q;
                    e1_d = push_ent;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q          <= '0;
            y_q          <= '0;
            row_q        <= '0;
            rd_q         <= 1'b0;
            rd_sof_q     <= 1'b0;
            rd_eol_q     <= 1'b0;
            occ_q        <= 2'd0;
            e0_q         <= '0;
            e1_q         <= '0;
            frame_done_q <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            row_q        <= row_d;
            rd_q         <= issue;
            rd_sof_q     <= issue && (x_q == '0) && (y_q == '0);
            rd_eol_q     <= issue && x_last;
            occ_q        <= occ_d;
            e0_q         <= e0_d;
            e1_q         <= e1_d;
            frame_done_q <= (state_q == DRAIN) && (state_d == IDLE);
        end
    end

    assign m_valid    = (occ_q != 2'd0);
    assign m_sof      = e0_q[EW-1];
    assign m_eol      = e0_q[EW-2];
    assign m_data     = e0_q[INDEX_WIDTH-1:0];
    assign frame_done = frame_done_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Bench for framebuffer_scanout at 4x2 with a registered-read framebuffer model holding value = address.
module tb_framebuffer_scanout;
    localparam int W = 4;
    localparam int H = 2;
`ifdef FRAMEBUFFER_SCANOUT_SCALE2X_EN
    localparam int NPIX = 32;
    localparam int STALL_ADDR = 1;
    localparam logic [5:0] EXP_TBL [32] = '{
        6'h20, 6'h00, 6'h01, 6'h01, 6'h02, 6'h02, 6'h03, 6'h13,
        6'h00, 6'h00, 6'h01, 6'h01, 6'h02, 6'h02, 6'h03, 6'h13,
        6'h04, 6'h04, 6'h05, 6'h05, 6'h06, 6'h06, 6'h07, 6'h17,
        6'h04, 6'h04, 6'h05, 6'h05, 6'h06, 6'h06, 6'h07, 6'h17};
`else
    localparam int NPIX = 8;
    localparam int STALL_ADDR = 2;
    localparam logic [5:0] EXP_TBL [8] = '{
        6'h20, 6'h01, 6'h02, 6'h13, 6'h04, 6'h05, 6'h06, 6'h17};
`endif

    logic       clk = 1'b0;
    logic       rst_n, start, m_ready;
    logic       busy, m_valid, m_sof, m_eol, frame_done;
    logic [2:0] fb_addr;
    logic [3:0] fb_data = 4'd0;
    logic [3:0] m_data;
    logic [1:0] state_dbg;

    int cyc = 0, t0 = 0, n_xfer = 0, n_done = 0, n_checks = 0, n_errors = 0;
    bit chk_time = 1'b0;
    bit stall_prev = 1'b0;
    logic [6:0] hold_bits;
    logic [5:0] exp_q[$];

    framebuffer_scanout #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .INDEX_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .fb_addr(fb_addr),
        .fb_data(fb_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_sof(m_sof), .m_eol(m_eol), .frame_done(frame_done), .state_dbg(state_dbg));

    // clock / reset-free timebase
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) fb_data <= 4'(fb_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_fb_addr"}, fb_addr, 0);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_data"}, m_data, 0);
        check({tag, "_m_sof"}, m_sof, 0);
        check({tag, "_m_eol"}, m_eol, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_state"}, state_dbg, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_expected();
        exp_q.delete();
        for (int k = 0; k < NPIX; k++) exp_q.push_back(EXP_TBL[k]);
    endtask

    function automatic logic rdy(input int mode, input int i);
        logic [3:0] pat;
        pat = 4'b1001;
        if (mode == 0) return 1'b1;
        if (i < 12) return 1'b0;
        return pat[3 - (i % 4)];
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        int rel;
        logic [5:0] exp_e;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            rel = cyc - t0;
            if (stall_prev) check("hold_while_stalled", {m_valid, m_sof, m_eol, m_data}, hold_bits);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_pixel", {m_sof, m_eol, m_data}, 32'hdead);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("pixel", {m_sof, m_eol, m_data}, exp_e);
                end
                if (chk_time) check("pixel_cycle", rel, 3 + n_xfer);
                n_xfer++;
            end
            if (frame_done) begin
                n_done++;
                check("busy_at_done", busy, 0);
                if (chk_time) check("done_cycle", rel, NPIX + 3);
            end
            stall_prev = m_valid && !m_ready;
            hold_bits  = {m_valid, m_sof, m_eol, m_data};
        end
    end

    task automatic run_frame(input int mode, input int restart_at, input bit timed);
        int done0;
        bit ok;
        done0    = n_done;
        n_xfer   = 0;
        ok       = 1'b0;
        chk_time = timed;
        start    = 1'b1;
        t0       = cyc;
        m_ready  = rdy(mode, 0);
        tick();
        for (int i = 1; i < 400; i++) begin
            if (timed && i == 1) begin
                check("busy_rise", busy, 1);
                check("first_addr", fb_addr, 0);
            end
            if (mode == 1 && i == 12) begin
                check("stall_addr", fb_addr, STALL_ADDR);
                check("stall_valid", m_valid, 1);
            end
            start   = (i == restart_at);
            m_ready = rdy(mode, i);
            tick();
            if (n_done != done0) begin
                ok = 1'b1;
                break;
            end
        end
        start   = 1'b0;
        m_ready = 1'b1;
        check("frame_finished", ok, 1);
        repeat (3) tick();
        check("done_count", n_done - done0, 1);
        check("xfer_count", n_xfer, NPIX);
        check("queue_empty", exp_q.size(), 0);
        check("busy_idle", busy, 0);
        chk_time = 1'b0;
    endtask

    initial begin
        int d0;
        rst_n   = 1'b0;
        start   = 1'b0;
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("por");
        rst_n = 1'b1;
        tick();
        tick();

        load_expected();
        run_frame(0, -1, 1'b1);

        load_expected();
        run_frame(1, -1, 1'b0);

        load_expected();
        run_frame(0, 5, 1'b1);

        // mid-frame reset at cycle 6
        load_expected();
        n_xfer   = 0;
        chk_time = 1'b1;
        m_ready  = 1'b1;
        start    = 1'b1;
        t0       = cyc;
        tick();
        start = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        @(negedge clk);
        check_reset("mid_rst");
        tick();
        @(negedge clk);
        check_reset("mid_rst_hold");
        rst_n    = 1'b1;
        chk_time = 1'b0;
        exp_q.delete();
        d0 = n_done;
        repeat (3) tick();
        check("no_done_after_reset", n_done, d0);
        check("no_stale_valid", m_valid, 0);

        load_expected();
        run_frame(0, -1, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
